// File: rtl/alu_unit_pkg.sv
// rtl/alu_unit_pkg.sv - ALU operation codes, type-field width and jump classification
// MUL codes are always defined; ALU_MUL_EN only decides whether alu_unit implements them.
`ifndef RS_TYPE_WIDTH
`define RS_TYPE_WIDTH 6
`endif

package alu_unit_pkg;

    localparam int RS_TYPE_WIDTH = `RS_TYPE_WIDTH;

    typedef logic [RS_TYPE_WIDTH-1:0] alu_type_t;

    localparam alu_type_t ALU_ADD      = alu_type_t'(0);
    localparam alu_type_t ALU_SUB      = alu_type_t'(1);
    localparam alu_type_t ALU_AND      = alu_type_t'(2);
    localparam alu_type_t ALU_OR       = alu_type_t'(3);
    localparam alu_type_t ALU_XOR      = alu_type_t'(4);
    localparam alu_type_t ALU_SLL      = alu_type_t'(5);
    localparam alu_type_t ALU_SRL      = alu_type_t'(6);
    localparam alu_type_t ALU_SRA      = alu_type_t'(7);
    localparam alu_type_t ALU_SLT      = alu_type_t'(8);
    localparam alu_type_t ALU_SLTU     = alu_type_t'(9);
    localparam alu_type_t ALU_ADDI     = alu_type_t'(10);
    localparam alu_type_t ALU_ANDI     = alu_type_t'(11);
    localparam alu_type_t ALU_ORI      = alu_type_t'(12);
    localparam alu_type_t ALU_XORI     = alu_type_t'(13);
    localparam alu_type_t ALU_SLLI     = alu_type_t'(14);
    localparam alu_type_t ALU_SRLI     = alu_type_t'(15);
    localparam alu_type_t ALU_SRAI     = alu_type_t'(16);
    localparam alu_type_t ALU_SLTI     = alu_type_t'(17);
    localparam alu_type_t ALU_SLTIU    = alu_type_t'(18);
    localparam alu_type_t ALU_LUI      = alu_type_t'(19);
    localparam alu_type_t ALU_AUIPC    = alu_type_t'(20);
    localparam alu_type_t ALU_JAL_LINK = alu_type_t'(21);
    localparam alu_type_t ALU_BEQ      = alu_type_t'(22);
    localparam alu_type_t ALU_BNE      = alu_type_t'(23);
    localparam alu_type_t ALU_BLT      = alu_type_t'(24);
    localparam alu_type_t ALU_BGE      = alu_type_t'(25);
    localparam alu_type_t ALU_BLTU     = alu_type_t'(26);
    localparam alu_type_t ALU_BGEU     = alu_type_t'(27);
    localparam alu_type_t ALU_JALR     = alu_type_t'(28);
    localparam alu_type_t ALU_MUL      = alu_type_t'(29);
    localparam alu_type_t ALU_MULH     = alu_type_t'(30);
    localparam alu_type_t ALU_MULHSU   = alu_type_t'(31);
    localparam alu_type_t ALU_MULHU    = alu_type_t'(32);

    // True for ops whose result may be a redirect PC for the ROB.
    function automatic logic has_jump(input alu_type_t t);
        case (t)
            ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE,
            ALU_BLTU, ALU_BGEU, ALU_JALR: has_jump = 1'b1;
            default:                      has_jump = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_unit_if.sv
// rtl/alu_unit_if.sv - issue and result bus between the reservation station and the ALU
interface alu_unit_if #(
    parameter int ID_W   = 32,
    parameter int TYPE_W = `RS_TYPE_WIDTH
);
    logic              alu_en;
    logic [ID_W-1:0]   alu_rob_id_in;
    logic [31:0]       alu_data_j;
    logic [31:0]       alu_data_k;
    logic [31:0]       alu_imm;
    logic [TYPE_W-1:0] alu_type;

    logic              alu_rdy;
    logic [ID_W-1:0]   alu_rob_id_out;
    logic [31:0]       alu_result;
    logic              alu_set_jump_addr;

    modport master (
        output alu_en, alu_rob_id_in, alu_data_j, alu_data_k, alu_imm, alu_type,
        input  alu_rdy, alu_rob_id_out, alu_result, alu_set_jump_addr
    );

    modport slave (
        input  alu_en, alu_rob_id_in, alu_data_j, alu_data_k, alu_imm, alu_type,
        output alu_rdy, alu_rob_id_out, alu_result, alu_set_jump_addr
    );
endinterface

// File: rtl/alu_branch_cmp.sv
// rtl/alu_branch_cmp.sv - combinational branch condition evaluation on operands j,k
// Non-branch types always report not-taken.
module alu_branch_cmp
    import alu_unit_pkg::*;
(
    input  logic [31:0] data_j_i,
    input  logic [31:0] data_k_i,
    input  alu_type_t   type_i,
    output logic        taken_o
);
    always_comb begin
        taken_o = 1'b0;
        case (type_i)
            ALU_BEQ:  taken_o = (data_j_i == data_k_i);
            ALU_BNE:  taken_o = (data_j_i != data_k_i);
            ALU_BLT:  taken_o = ($signed(data_j_i) <  $signed(data_k_i));
            ALU_BGE:  taken_o = ($signed(data_j_i) >= $signed(data_k_i));
            ALU_BLTU: taken_o = (data_j_i <  data_k_i);
            ALU_BGEU: taken_o = (data_j_i >= data_k_i);
            default:  taken_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - two-stage pipelined ALU answering the reservation station issue bus
// Define ALU_MUL_EN to add MUL/MULH/MULHSU/MULHU; otherwise those codes return 0.
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int TYPE_W = `RS_TYPE_WIDTH,
    parameter int ID_W   = 32
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    input  logic      flush,
    alu_unit_if.slave bus
);
    logic              s1_valid_q,  s1_valid_d;
    logic [ID_W-1:0]   s1_rob_id_q, s1_rob_id_d;
    logic [31:0]       s1_j_q,      s1_j_d;
    logic [31:0]       s1_k_q,      s1_k_d;
    logic [31:0]       s1_imm_q,    s1_imm_d;
    alu_type_t         s1_type_q,   s1_type_d;

    logic              out_rdy_q,    out_rdy_d;
    logic [ID_W-1:0]   out_rob_id_q, out_rob_id_d;
    logic [31:0]       out_result_q, out_result_d;
    logic              out_jump_q,   out_jump_d;

    logic [TYPE_W-1:0] issue_type;
    logic              br_taken;
    logic [31:0]       exec_result;
    logic              exec_jump;

    assign issue_type = bus.alu_type;

`ifdef ALU_MUL_EN
    // Unsigned 16x16 partial products; signedness is corrected in S2.
    logic [31:0] pp_ll_q, pp_ll_d;
    logic [31:0] pp_lh_q, pp_lh_d;
    logic [31:0] pp_hl_q, pp_hl_d;
    logic [31:0] pp_hh_q, pp_hh_d;
    logic [63:0] prod_uu;
    logic [63:0] prod_su;
    logic [63:0] prod_ss;

    always_comb begin
        prod_uu = {32'd0, pp_ll_q}
                + {16'd0, pp_lh_q, 16'd0}
                + {16'd0, pp_hl_q, 16'd0}
                + {pp_hh_q, 32'd0};
        // A negative operand x contributes x_u - 2^32, so subtract the other operand shifted by 32.
        prod_su = prod_uu - (s1_j_q[31] ? {s1_k_q, 32'd0} : 64'd0);
        prod_ss = prod_su - (s1_k_q[31] ? {s1_j_q, 32'd0} : 64'd0);
    end
`endif

    alu_branch_cmp u_branch_cmp (
        .data_j_i (s1_j_q),
        .data_k_i (s1_k_q),
        .type_i   (s1_type_q),
        .taken_o  (br_taken)
    );

    always_comb begin
        exec_result = 32'd0;
        case (s1_type_q)
            ALU_ADD:      exec_result = s1_j_q + s1_k_q;
            ALU_SUB:      exec_result = s1_j_q - s1_k_q;
            ALU_AND:      exec_result = s1_j_q & s1_k_q;
            ALU_OR:       exec_result = s1_j_q | s1_k_q;
            ALU_XOR:      exec_result = s1_j_q ^ s1_k_q;
            ALU_SLL:      exec_result = s1_j_q << s1_k_q[4:0];
            ALU_SRL:      exec_result = s1_j_q >> s1_k_q[4:0];
            ALU_SRA:      exec_result = $unsigned($signed(s1_j_q) >>> s1_k_q[4:0]);
            ALU_SLT:      exec_result = {31'd0, $signed(s1_j_q) < $signed(s1_k_q)};
            ALU_SLTU:     exec_result = {31'd0, s1_j_q < s1_k_q};
            ALU_ADDI:     exec_result = s1_j_q + s1_imm_q;
            ALU_ANDI:     exec_result = s1_j_q & s1_imm_q;
            ALU_ORI:      exec_result = s1_j_q | s1_imm_q;
            ALU_XORI:     exec_result = s1_j_q ^ s1_imm_q;
            ALU_SLLI:     exec_result = s1_j_q << s1_imm_q[4:0];
            ALU_SRLI:     exec_result = s1_j_q >> s1_imm_q[4:0];
            ALU_SRAI:     exec_result = $unsigned($signed(s1_j_q) >>> s1_imm_q[4:0]);
            ALU_SLTI:     exec_result = {31'd0, $signed(s1_j_q) < $signed(s1_imm_q)};
            ALU_SLTIU:    exec_result = {31'd0, s1_j_q < s1_imm_q};
            ALU_LUI:      exec_result = s1_imm_q;
            ALU_AUIPC:    exec_result = s1_k_q + s1_imm_q;
            ALU_JAL_LINK: exec_result = s1_k_q + 32'd4;
            ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU:
                          exec_result = br_taken ? s1_imm_q : 32'd0;
            ALU_JALR:     exec_result = (s1_j_q + s1_imm_q) & ~32'd1;
`ifdef ALU_MUL_EN
            ALU_MUL:      exec_result = prod_uu[31:0];
            ALU_MULH:     exec_result = prod_ss[63:32];
            ALU_MULHSU:   exec_result = prod_su[63:32];
            ALU_MULHU:    exec_result = prod_uu[63:32];
`else
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU:
                          exec_result = 32'd0;
`endif
            default:      exec_result = 32'd0;
        endcase
    end

    assign exec_jump = has_jump(s1_type_q) && ((s1_type_q == ALU_JALR) || br_taken);

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_rob_id_d  = s1_rob_id_q;
        s1_j_d       = s1_j_q;
        s1_k_d       = s1_k_q;
        s1_imm_d     = s1_imm_q;
        s1_type_d    = s1_type_q;
        out_rdy_d    = out_rdy_q;
        out_rob_id_d = out_rob_id_q;
        out_result_d = out_result_q;
        out_jump_d   = out_jump_q;
`ifdef ALU_MUL_EN
        pp_ll_d = pp_ll_q;
        pp_lh_d = pp_lh_q;
        pp_hl_d = pp_hl_q;
        pp_hh_d = pp_hh_q;
`endif
        if (rdy_in) begin
            if (flush) begin
                // Payloads keep stale data; only the valid bits matter.
                s1_valid_d = 1'b0;
                out_rdy_d  = 1'b0;
            end else begin
                s1_valid_d = bus.alu_en;
                if (bus.alu_en) begin
                    s1_rob_id_d = bus.alu_rob_id_in;
                    s1_j_d      = bus.alu_data_j;
                    s1_k_d      = bus.alu_data_k;
                    s1_imm_d    = bus.alu_imm;
                    s1_type_d   = alu_type_t'(issue_type);
`ifdef ALU_MUL_EN
                    pp_ll_d = {16'd0, bus.alu_data_j[15:0]}  * {16'd0, bus.alu_data_k[15:0]};
                    pp_lh_d = {16'd0, bus.alu_data_j[15:0]}  * {16'd0, bus.alu_data_k[31:16]};
                    pp_hl_d = {16'd0, bus.alu_data_j[31:16]} * {16'd0, bus.alu_data_k[15:0]};
                    pp_hh_d = {16'd0, bus.alu_data_j[31:16]} * {16'd0, bus.alu_data_k[31:16]};
`endif
                end
                out_rdy_d = s1_valid_q;
                if (s1_valid_q) begin
                    out_rob_id_d = s1_rob_id_q;
                    out_result_d = exec_result;
                    out_jump_d   = exec_jump;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid_q   <= 1'b0;
            s1_rob_id_q  <= '0;
            s1_j_q       <= 32'd0;
            s1_k_q       <= 32'd0;
            s1_imm_q     <= 32'd0;
            s1_type_q    <= '0;
            out_rdy_q    <= 1'b0;
            out_rob_id_q <= '0;
            out_result_q <= 32'd0;
            out_jump_q   <= 1'b0;
`ifdef ALU_MUL_EN
            pp_ll_q <= 32'd0;
            pp_lh_q <= 32'd0;
            pp_hl_q <= 32'd0;
            pp_hh_q <= 32'd0;
`endif
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_rob_id_q  <= s1_rob_id_d;
            s1_j_q       <= s1_j_d;
            s1_k_q       <= s1_k_d;
            s1_imm_q     <= s1_imm_d;
            s1_type_q    <= s1_type_d;
            out_rdy_q    <= out_rdy_d;
            out_rob_id_q <= out_rob_id_d;
            out_result_q <= out_result_d;
            out_jump_q   <= out_jump_d;
`ifdef ALU_MUL_EN
            pp_ll_q <= pp_ll_d;
            pp_lh_q <= pp_lh_d;
            pp_hl_q <= pp_hl_d;
            pp_hh_q <= pp_hh_d;
`endif
        end
    end

    assign bus.alu_rdy           = out_rdy_q;
    assign bus.alu_rob_id_out    = out_rob_id_q;
    assign bus.alu_result        = out_result_q;
    assign bus.alu_set_jump_addr = out_jump_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - randomized scoreboard bench for alu_unit against a behavioural reference
module tb_alu_unit;
    import alu_unit_pkg::*;

    localparam int ID_W   = 32;
    localparam int TYPE_W = RS_TYPE_WIDTH;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic flush;

    alu_unit_if #(.ID_W(ID_W), .TYPE_W(TYPE_W)) bus ();

    alu_unit #(.TYPE_W(TYPE_W), .ID_W(ID_W)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     result;
        logic            jump;
        int              due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic        cur_rdy = 1'b0;
    int          eff_cnt = 0;
    int          last_eff = 0;
    int          checks = 0;
    int          failures = 0;
    logic [32:0] mdl_r;

    // Returns {jump, result} straight from the instruction semantics.
    function automatic logic [32:0] ref_model(input logic [TYPE_W-1:0] t, input logic [31:0] j,
                                              input logic [31:0] k, input logic [31:0] imm);
        int          sj;
        int          sk;
        int          si;
        logic [31:0] r;
        logic        jmp;
        logic        taken;
        logic [63:0] p;
        sj = int'(j);
        sk = int'(k);
        si = int'(imm);
        r = 32'd0;
        jmp = 1'b0;
        taken = 1'b0;
        p = 64'd0;
        case (t)
            ALU_ADD:      r = j + k;
            ALU_SUB:      r = j - k;
            ALU_AND:      r = j & k;
            ALU_OR:       r = j | k;
            ALU_XOR:      r = j ^ k;
            ALU_SLL:      r = j << k[4:0];
            ALU_SRL:      r = j >> k[4:0];
            ALU_SRA:      r = 32'(sj >>> k[4:0]);
            ALU_SLT:      r = (sj < sk) ? 32'd1 : 32'd0;
            ALU_SLTU:     r = (j < k) ? 32'd1 : 32'd0;
            ALU_ADDI:     r = j + imm;
            ALU_ANDI:     r = j & imm;
            ALU_ORI:      r = j | imm;
            ALU_XORI:     r = j ^ imm;
            ALU_SLLI:     r = j << imm[4:0];
            ALU_SRLI:     r = j >> imm[4:0];
            ALU_SRAI:     r = 32'(sj >>> imm[4:0]);
            ALU_SLTI:     r = (sj < si) ? 32'd1 : 32'd0;
            ALU_SLTIU:    r = (j < imm) ? 32'd1 : 32'd0;
            ALU_LUI:      r = imm;
            ALU_AUIPC:    r = k + imm;
            ALU_JAL_LINK: r = k + 32'd4;
            ALU_BEQ:      taken = (j == k);
            ALU_BNE:      taken = (j != k);
            ALU_BLT:      taken = (sj < sk);
            ALU_BGE:      taken = (sj >= sk);
            ALU_BLTU:     taken = (j < k);
            ALU_BGEU:     taken = (j >= k);
            ALU_JALR: begin
                r = (j + imm) & 32'hFFFF_FFFE;
                jmp = 1'b1;
            end
`ifdef ALU_MUL_EN
            ALU_MUL: begin
                p = {32'd0, j} * {32'd0, k};
                r = p[31:0];
            end
            ALU_MULH: begin
                p = 64'(longint'(sj) * longint'(sk));
                r = p[63:32];
            end
            ALU_MULHSU: begin
                p = 64'(longint'(sj) * longint'({32'd0, k}));
                r = p[63:32];
            end
            ALU_MULHU: begin
                p = {32'd0, j} * {32'd0, k};
                r = p[63:32];
            end
`endif
            default: r = 32'd0;
        endcase
        if (taken) begin
            r = imm;
            jmp = 1'b1;
        end
        return {jmp, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, req, eff_cnt);
        end
    endtask

    // Reference: every accepted issue is due two effective cycles later; flush drops all pending.
    always @(posedge clk_in) begin
        if (rst_in) begin
            exp_q.delete();
            eff_cnt = 0;
        end else if (rdy_in) begin
            eff_cnt++;
            if (flush) begin
                exp_q.delete();
            end else if (bus.alu_en) begin
                mdl_r = ref_model(bus.alu_type, bus.alu_data_j, bus.alu_data_k, bus.alu_imm);
                exp_q.push_back('{id: bus.alu_rob_id_in, result: mdl_r[31:0], jump: mdl_r[32],
                                  due: eff_cnt + 1});
            end
        end
    end

    always @(negedge clk_in) begin
        if (rst_in) begin
            cur_rdy = 1'b0;
            last_eff = 0;
        end else begin
            if (eff_cnt != last_eff) begin
                last_eff = eff_cnt;
                cur_rdy = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].due == eff_cnt) begin
                    cur = exp_q.pop_front();
                    cur_rdy = 1'b1;
                end
            end
            check("alu_rdy", {31'd0, bus.alu_rdy}, {31'd0, cur_rdy});
            if (cur_rdy && bus.alu_rdy) begin
                check("alu_rob_id_out", bus.alu_rob_id_out, cur.id);
                check("alu_result", bus.alu_result, cur.result);
                check("alu_set_jump_addr", {31'd0, bus.alu_set_jump_addr}, {31'd0, cur.jump});
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [TYPE_W-1:0] t, input logic [31:0] j, input logic [31:0] k,
                         input logic [31:0] imm, input logic [ID_W-1:0] id);
        bus.alu_en        = 1'b1;
        bus.alu_type      = t;
        bus.alu_data_j    = j;
        bus.alu_data_k    = k;
        bus.alu_imm       = imm;
        bus.alu_rob_id_in = id;
    endtask

    task automatic idle(input int n);
        bus.alu_en = 1'b0;
        repeat (n) step();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [TYPE_W-1:0] rand_type();
        int t;
        t = $urandom_range(0, 40);
        if (t == 40) t = (1 << TYPE_W) - 1;
        return TYPE_W'(t);
    endfunction

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        flush  = 1'b0;
        bus.alu_en = 1'b0;
        bus.alu_type = '0;
        bus.alu_data_j = 32'd0;
        bus.alu_data_k = 32'd0;
        bus.alu_imm = 32'd0;
        bus.alu_rob_id_in = '0;
        repeat (3) step();
        check("reset alu_rdy", {31'd0, bus.alu_rdy}, 32'd0);
        check("reset alu_rob_id_out", bus.alu_rob_id_out, 32'd0);
        check("reset alu_result", bus.alu_result, 32'd0);
        check("reset alu_set_jump_addr", {31'd0, bus.alu_set_jump_addr}, 32'd0);
        rst_in = 1'b0;

        drive(ALU_ADD, 32'd5, 32'd7, 32'd0, 32'd3);
        step();
        idle(4);

        drive(ALU_SUB, 32'd0, 32'd1, 32'd0, 32'd1);
        step();
        drive(ALU_SRA, 32'h8000_0000, 32'd4, 32'd0, 32'd2);
        step();
        drive(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd3);
        step();
        idle(4);

        drive(ALU_BLT, 32'hFFFF_FFFF, 32'd0, 32'h100, 32'd4);
        step();
        drive(ALU_BGEU, 32'hFFFF_FFFF, 32'd0, 32'h100, 32'd5);
        step();
        drive(ALU_JALR, 32'h1003, 32'd0, 32'd0, 32'd6);
        step();
        idle(4);

        drive(ALU_ADD, 32'd1, 32'd2, 32'd0, 32'd7);
        step();
        drive(ALU_ADD, 32'd3, 32'd4, 32'd0, 32'd8);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle(4);

        drive(ALU_ADD, 32'd10, 32'd20, 32'd0, 32'd9);
        step();
        rdy_in = 1'b0;
        drive(ALU_XOR, 32'hAAAA_AAAA, 32'h5555_5555, 32'd0, 32'd99);
        repeat (3) step();
        rdy_in = 1'b1;
        idle(4);

        drive(ALU_MULH, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd10);
        step();
        drive(ALU_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd11);
        step();
        drive(ALU_MUL, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd12);
        step();
        drive(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd13);
        step();
        idle(4);

        for (int n = 0; n < 3000; n++) begin
            rdy_in = ($urandom_range(0, 7) != 0);
            flush  = ($urandom_range(0, 39) == 0);
            drive(rand_type(), rand_operand(), rand_operand(), rand_operand(), $urandom());
            if ($urandom_range(0, 3) == 0) bus.alu_data_k = bus.alu_data_j;
            bus.alu_en = ($urandom_range(0, 3) != 0);
            step();
        end
        rdy_in = 1'b1;
        flush  = 1'b0;
        idle(5);
        check("pending results drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
